fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch front end that sits directly upstream of the IF/ID pipeline register. It issues sequential PC requests to instruction memory over a valid/ready request channel and accepts in-order responses of variable latency. Fetched words are buffered in a small queue and presented to decode as {instr, pc_plus4} with a valid/ready handshake. A taken-branch redirect from EX/MEM flushes the queue and discards any in-flight stale responses.

Parameters:
PC_SIZE, 32, width of PC and instruction-memory address.
INSTR_SIZE, 32, instruction word width.
RESET_PC, 0, PC of the first fetch after reset.
DEPTH, 4, instruction-queue entries; power of 2 and at least 2; also bounds the number of outstanding requests.

Ports:
clk  in  1  clock; all state changes on posedge.
rst_n  in  1  asynchronous active-low reset.
redirect_i  in  1  taken branch; takes priority over all other events.
redirect_pc_i  in  PC_SIZE  branch target; bits [1:0] are ignored and treated as 0.
imem_req_valid_o  out  1  fetch request valid.
imem_req_ready_i  in  1  memory accepts the request.
imem_req_addr_o  out  PC_SIZE  fetch address (current fetch_pc).
imem_rsp_valid_i  in  1  response word valid; responses return in request order, at least 1 cycle after request acceptance.
imem_rsp_data_i  in  INSTR_SIZE  instruction word.
out_valid_o  out  1  queue head valid to decode.
out_ready_i  in  1  decode accepts the head (deasserted while decode stalls).
out_instr_o  out  INSTR_SIZE  head instruction.
out_pc_plus4_o  out  PC_SIZE  head PC + 4.

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - fetch_pc and rsp_pc are set to RESET_PC.
  - occupancy, outstanding, stale_cnt, rd_ptr and wr_ptr are set to 0.
  - imem_req_valid_o=0, out_valid_o=0; out_instr_o and out_pc_plus4_o read as 0.
  - Asserting reset mid-operation drops all in-flight state immediately. Responses arriving after reset release are not counted as outstanding and are ignored.
- Request issue:
  - imem_req_valid_o = !redirect_i && (occupancy + outstanding < DEPTH). This is combinational from the registered counts and redirect_i.
  - The first request is asserted in the first cycle after rst_n rises.
  - On handshake (valid && ready): fetch_pc += 4 (wraps modulo 2^PC_SIZE) and outstanding += 1.
  - valid may be held while ready=0; addr stays stable while valid is held, except when a redirect occurs.
- Response handling:
  - Every imem_rsp_valid_i decrements outstanding.
  - If stale_cnt>0: the word is dropped and stale_cnt -= 1.
  - Otherwise the word is written at wr_ptr with pc_plus4 = rsp_pc + 4. Then rsp_pc += 4, wr_ptr += 1 (wraps at DEPTH), occupancy += 1.
  - A response with outstanding==0 is a protocol error; it is ignored (bench asserts this).
- Output:
  - out_valid_o = (occupancy != 0); the outputs show the entry at rd_ptr.
  - Pop on out_valid_o && out_ready_i: rd_ptr += 1 (wraps), occupancy -= 1.
  - There is no bypass: a response in cycle N is visible at the output in cycle N+1 at the earliest.
- Simultaneous push and pop: occupancy is unchanged. The credit rule guarantees a push never overflows, including when the queue is full and popping.
- Redirect (cycle R, redirect_i=1):
  - Queue flushed: occupancy, rd_ptr and wr_ptr go to 0, so out_valid_o=0 in cycle R+1. A pop in cycle R is ignored.
  - fetch_pc and rsp_pc are set to {redirect_pc_i[PC_SIZE-1:2], 2'b00}. Request valid is forced to 0 in cycle R; the new target is requested from R+1.
  - stale_cnt_next = outstanding − (imem_rsp_valid_i ? 1 : 0). Any response arriving in cycle R is dropped.
  - Back-to-back redirects: each one recomputes stale_cnt from the current outstanding count; the last target wins.
- Counters are sized clog2(DEPTH)+1 bits. occupancy + outstanding ≤ DEPTH at all times.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds ports perf_stall_cnt_o (out, 32) and perf_drop_cnt_o (out, 32), both reset to 0.
  - perf_stall_cnt_o increments each cycle where out_valid_o=1 and out_ready_i=0.
  - perf_drop_cnt_o increments on each dropped stale response.
  - Both counters saturate at 2^32−1.
- Undefined: ports and logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset release, memory ready=1 with latency 1, out_ready=1 → request addresses 0x0, 0x4, 0x8…; outputs {instr0, pc_plus4=0x4}, {instr1, 0x8} at one per cycle after the pipeline fills.
- Hold out_ready=0, latency 1 → exactly DEPTH=4 requests issued (0x0–0xC), then imem_req_valid_o=0. Queue full and out_valid_o=1 holding instr at 0x0. Release out_ready → entries drain in order and requests resume at 0x10.
- Latency 3 with 3 requests outstanding; redirect_i=1 with redirect_pc=0x103 → next request addr 0x100. The 3 old responses are dropped; the first output is {instr@0x100, 0x104}; with perf enabled, perf_drop_cnt_o=3.
- Redirect in the same cycle as a response and a pop → response dropped, pop ignored, out_valid_o=0 next cycle, stale_cnt = outstanding−1.
- fetch_pc=0xFFFFFFFC → next request addr wraps to 0x0; out_pc_plus4_o=0x0 for that word.
- Pull rst_n low with 2 requests outstanding and 2 entries queued → outputs immediately 0. After release, the first request is 0x0 (RESET_PC) and late old responses are ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited sequential requests, in-order responses into a small queue.
// Optional FETCH_PERF_CNT_EN adds saturating stall/drop performance counters.
module fetch_unit #(
   parameter int                  PC_SIZE    = 32,
   parameter int                  INSTR_SIZE = 32,
   parameter logic [PC_SIZE-1:0]  RESET_PC   = '0,
   parameter int                  DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  redirect_i,
   input  logic [PC_SIZE-1:0]    redirect_pc_i,
   output logic                  imem_req_valid_o,
   input  logic                  imem_req_ready_i,
   output logic [PC_SIZE-1:0]    imem_req_addr_o,
   input  logic                  imem_rsp_valid_i,
   input  logic [INSTR_SIZE-1:0] imem_rsp_data_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [INSTR_SIZE-1:0] out_instr_o,
   output logic [PC_SIZE-1:0]    out_pc_plus4_o
`ifdef FETCH_PERF_CNT_EN
  ,output logic [31:0]           perf_stall_cnt_o,
   output logic [31:0]           perf_drop_cnt_o
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   logic [PC_SIZE-1:0]    fetch_pc_q, fetch_pc_d;
   logic [PC_SIZE-1:0]    rsp_pc_q, rsp_pc_d;
   logic [CW-1:0]         occ_q, occ_d;
   logic [CW-1:0]         outst_q, outst_d;
   logic [CW-1:0]         stale_q, stale_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [INSTR_SIZE-1:0] instr_q [DEPTH];
   logic [PC_SIZE-1:0]    pcp4_q  [DEPTH];

   logic                  credit_ok, req_hs, rsp_acc, rsp_drop, push, pop;
   logic [PC_SIZE-1:0]    tgt_pc;
   logic                  unused_pc_lsbs;

   assign unused_pc_lsbs = &{1'b0, redirect_pc_i[1:0]};
   assign tgt_pc         = {redirect_pc_i[PC_SIZE-1:2], 2'b00};

   // Credits count both queued words and words still in flight, so a push can never overflow.
   assign credit_ok        = ({1'b0, occ_q} + {1'b0, outst_q}) < DEPTH_W;
   assign imem_req_valid_o = rst_n && !redirect_i && credit_ok;
   assign imem_req_addr_o  = fetch_pc_q;
   assign req_hs           = imem_req_valid_o && imem_req_ready_i;

   // A response with nothing outstanding is a protocol violation and is ignored.
   assign rsp_acc  = imem_rsp_valid_i && (outst_q != '0);
   assign rsp_drop = rsp_acc && (redirect_i || (stale_q != '0));
   assign push     = rsp_acc && !rsp_drop;

   assign out_valid_o    = (occ_q != '0);
   assign out_instr_o    = out_valid_o ? instr_q[rd_ptr_q] : '0;
   assign out_pc_plus4_o = out_valid_o ? pcp4_q[rd_ptr_q]  : '0;
   assign pop            = out_valid_o && out_ready_i && !redirect_i;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      stale_d    = stale_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      outst_d    = outst_q + CW'(req_hs) - CW'(rsp_acc);
      occ_d      = occ_q + CW'(push) - CW'(pop);
      if (req_hs) fetch_pc_d = fetch_pc_q + PC_SIZE'(4);
      if (rsp_acc && (stale_q != '0)) stale_d = stale_q - CW'(1);
      if (push) begin
         rsp_pc_d = rsp_pc_q + PC_SIZE'(4);
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      // Everything still in flight after this cycle belongs to the old path.
      if (redirect_i) begin
         fetch_pc_d = tgt_pc;
         rsp_pc_d   = tgt_pc;
         occ_d      = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         stale_d    = outst_q - CW'(rsp_acc);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         occ_q      <= '0;
         outst_q    <= '0;
         stale_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         occ_q      <= occ_d;
         outst_q    <= outst_d;
         stale_q    <= stale_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         instr_q[wr_ptr_q] <= imem_rsp_data_i;
         pcp4_q[wr_ptr_q]  <= rsp_pc_q + PC_SIZE'(4);
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt_q, drop_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         if (out_valid_o && !out_ready_i && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (rsp_drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 32'd1;
      end
   end

   assign perf_stall_cnt_o = stall_cnt_q;
   assign perf_drop_cnt_o  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a memory model tags requests with a path epoch,
// and the expected decode stream is derived from which responses belong to the current path.
module tb_fetch_unit;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        imem_req_valid_o;
   logic        imem_req_ready_i = 1'b0;
   logic [31:0] imem_req_addr_o;
   logic        imem_rsp_valid_i = 1'b0;
   logic [31:0] imem_rsp_data_i = '0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;
   logic [31:0] out_instr_o;
   logic [31:0] out_pc_plus4_o;

   always #5 clk = ~clk;

   fetch_unit #(.PC_SIZE(32), .INSTR_SIZE(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .redirect_i       (redirect_i),
      .redirect_pc_i    (redirect_pc_i),
      .imem_req_valid_o (imem_req_valid_o),
      .imem_req_ready_i (imem_req_ready_i),
      .imem_req_addr_o  (imem_req_addr_o),
      .imem_rsp_valid_i (imem_rsp_valid_i),
      .imem_rsp_data_i  (imem_rsp_data_i),
      .out_valid_o      (out_valid_o),
      .out_ready_i      (out_ready_i),
      .out_instr_o      (out_instr_o),
      .out_pc_plus4_o   (out_pc_plus4_o)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          epoch;
      int          rdy;
   } req_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pcp4;
   } out_t;

   req_t        pend[$];
   out_t        exp_q[$];
   logic [31:0] next_pc = '0;
   int          epoch = 0;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   int          p_ready = 100, p_rsp = 100, p_out = 100, p_redir = 0;
   int          lat_min = 1, lat_max = 1;
   int          redir_req = 0, redir_done = 0;
   logic [31:0] redir_tgt = '0;
   int          stray_until = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
      end
   endtask

   // Stimulus: memory responder, decode back-pressure and redirects.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         redirect_i       = 1'b0;
         imem_req_ready_i = 1'b0;
         imem_rsp_valid_i = 1'b0;
         out_ready_i      = 1'b0;
      end else begin
         imem_req_ready_i = ($urandom_range(99) < p_ready);
         out_ready_i      = ($urandom_range(99) < p_out);
         if (redir_req != redir_done) begin
            redir_done    = redir_req;
            redirect_i    = 1'b1;
            redirect_pc_i = redir_tgt;
         end else begin
            redirect_i    = ($urandom_range(999) < p_redir);
            redirect_pc_i = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                     : ($urandom & 32'h0000_0FFF);
         end
         if (pend.size() > 0 && pend[0].rdy <= cyc && $urandom_range(99) < p_rsp) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = pend[0].data;
         end else if (pend.size() == 0 && cyc <= stray_until) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = $urandom;
         end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = $urandom;
         end
      end
   end

   // Monitor: compare against the model state, then advance the model with this cycle's events.
   always @(negedge clk) begin
      #3;
      if (!rst_n) begin
         pend.delete();
         exp_q.delete();
         next_pc = 32'h0;
         epoch++;
         chk("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
         chk("rst_out_valid", 32'(out_valid_o), 32'd0);
         chk("rst_instr", out_instr_o, 32'd0);
         chk("rst_pc_plus4", out_pc_plus4_o, 32'd0);
      end else begin
         logic exp_v, exp_rv;
         exp_v  = (exp_q.size() != 0);
         exp_rv = !redirect_i && ((exp_q.size() + pend.size()) < DEPTH);
         chk("out_valid", 32'(out_valid_o), 32'(exp_v));
         if (exp_v && out_valid_o) begin
            chk("out_instr", out_instr_o, exp_q[0].instr);
            chk("out_pc_plus4", out_pc_plus4_o, exp_q[0].pcp4);
         end
         chk("req_valid", 32'(imem_req_valid_o), 32'(exp_rv));
         if (exp_rv && imem_req_valid_o) chk("req_addr", imem_req_addr_o, next_pc);

         if (exp_v && out_valid_o && out_ready_i && !redirect_i) void'(exp_q.pop_front());
         if (imem_rsp_valid_i && pend.size() > 0) begin
            req_t h;
            h = pend.pop_front();
            if (!redirect_i && h.epoch == epoch) exp_q.push_back('{instr: h.data, pcp4: h.addr + 32'd4});
         end
         if (imem_req_valid_o && imem_req_ready_i) begin
            pend.push_back('{addr: next_pc, data: $urandom, epoch: epoch,
                             rdy: cyc + int'($urandom_range(lat_max, lat_min))});
            next_pc = next_pc + 32'd4;
         end
         if (redirect_i) begin
            exp_q.delete();
            epoch++;
            next_pc = redirect_pc_i & 32'hFFFF_FFFC;
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   initial begin
      cycles(3);
      rst_n = 1'b1;

      // Streaming with single-cycle memory and a free-running decoder.
      cycles(20);

      // Decode stall fills the queue and throttles requests, then drains.
      p_out = 0;
      cycles(12);
      p_out = 100;
      cycles(12);

      // Latency 3 with several requests in flight, then redirect to a misaligned target.
      lat_min = 3; lat_max = 3;
      cycles(10);
      redir_tgt = 32'h0000_0103; redir_req++;
      cycles(15);

      // Redirect while responses and pops are happening every cycle.
      lat_min = 1; lat_max = 1;
      cycles(10);
      redir_tgt = 32'h0000_0400; redir_req++;
      cycles(2);
      redir_tgt = 32'h0000_0800; redir_req++;
      cycles(10);

      // Address wrap at the top of the PC space.
      redir_tgt = 32'hFFFF_FFF8; redir_req++;
      cycles(12);

      // Randomized traffic.
      p_ready = 70; p_rsp = 60; p_out = 60; p_redir = 30;
      lat_min = 1; lat_max = 4;
      cycles(3000);

      // Mid-operation reset, then stray responses with nothing outstanding.
      p_out = 30; lat_min = 2; lat_max = 3;
      cycles(20);
      rst_n = 1'b0;
      cycles(2);
      rst_n = 1'b1;
      p_ready = 0;
      stray_until = cyc + 2;
      cycles(3);
      p_ready = 70; p_out = 60;
      cycles(1000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
